// File: rtl/bram_pattern_tester.sv
// BRAM self-test engine: fills an inferred DEPTH x DATA_W RAM with a pattern, reads it back and checks it.
// Optional error injection on the write port is enabled with RAM_TEST_ERR_INJECT_EN.
module bram_pattern_tester #(
  parameter int          DATA_W = 32,
  parameter int          ADDR_W = 10,
  parameter int          DEPTH  = 1024,
  parameter logic [31:0] SEED   = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              loop,
  input  logic              stop,
`ifdef RAM_TEST_ERR_INJECT_EN
  input  logic              inject,
`endif
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data_out,
  output logic              read_valid
);

  localparam logic [31:0]       SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
  localparam logic [6:0]        BIT_LAST = 7'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t            state;
  logic [1:0]        mode_q;
  logic              loop_q;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       lfsr;
  logic [6:0]        bitpos;
  logic              err_seen;
  logic              pass_bad;
  logic [DATA_W-1:0] exp_q;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] pat;
  logic [DATA_W-1:0] wdata;
  logic              mismatch;
  logic              last_addr;
  logic [31:0]       lfsr_next;
  logic [6:0]        bitpos_next;
  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a,
                                                input logic [31:0] s, input logic [6:0] b);
    logic [63:0] v;
    case (m)
      2'd0:    v = 64'(a);
      2'd1:    v = 64'(SEED) + 64'(a);
      2'd2:    v = {s, s};
      default: v = 64'd1 << b;
    endcase
    return v[DATA_W-1:0];
  endfunction

  assign pat         = pattern(mode_q, addr, lfsr, bitpos);
  assign lfsr_next   = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  assign bitpos_next = (bitpos == BIT_LAST) ? 7'd0 : bitpos + 7'd1;
  assign last_addr   = (addr == LAST);
  assign mismatch    = read_valid && (ram_q != exp_q);
  assign read_data_out = read_valid ? ram_q : '0;

`ifdef RAM_TEST_ERR_INJECT_EN
  logic injected;
  logic inj_now;
  assign inj_now = inject && (state == WRITE) && !injected;
  assign wdata   = pat ^ DATA_W'(inj_now);
`else
  assign wdata   = pat;
`endif

  // RAM has no reset so it maps onto block RAM; the output is gated by read_valid instead.
  always_ff @(posedge clk) begin
    if (state == WRITE) mem[addr] <= wdata;
    ram_q <= mem[addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b1;
      err_count      <= '0;
      first_err_addr <= '0;
      read_addr      <= '0;
      read_valid     <= 1'b0;
      mode_q         <= 2'd0;
      loop_q         <= 1'b0;
      addr           <= '0;
      lfsr           <= SEED_EFF;
      bitpos         <= '0;
      err_seen       <= 1'b0;
      pass_bad       <= 1'b0;
      exp_q          <= '0;
`ifdef RAM_TEST_ERR_INJECT_EN
      injected       <= 1'b0;
`endif
    end else begin
      done       <= 1'b0;
      read_valid <= (state == READ);
      if (state == READ) begin
        read_addr <= addr;
        exp_q     <= pat;
      end
      if (stop && state != IDLE) loop_q <= 1'b0;
      if (mismatch) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (!err_seen) first_err_addr <= read_addr;
        err_seen <= 1'b1;
        pass_bad <= 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          mode_q         <= mode;
          loop_q         <= loop;
          err_count      <= '0;
          first_err_addr <= '0;
          err_seen       <= 1'b0;
          pass_bad       <= 1'b0;
          lfsr           <= SEED_EFF;
          addr           <= '0;
          bitpos         <= '0;
          busy           <= 1'b1;
          state          <= WRITE;
`ifdef RAM_TEST_ERR_INJECT_EN
          injected       <= 1'b0;
`endif
        end
        WRITE, READ: begin
`ifdef RAM_TEST_ERR_INJECT_EN
          if (inj_now) injected <= 1'b1;
`endif
          // Both phases walk the same sequence, so generator state rewinds at each phase end.
          if (last_addr) begin
            addr   <= '0;
            lfsr   <= SEED_EFF;
            bitpos <= '0;
            state  <= (state == WRITE) ? READ : DRAIN;
          end else begin
            addr   <= addr + 1'b1;
            lfsr   <= lfsr_next;
            bitpos <= bitpos_next;
          end
        end
        DRAIN: begin
          done  <= 1'b1;
          pass  <= !(pass_bad || mismatch);
          state <= DONE;
        end
        DONE: begin
          if (loop_q && !stop) begin
            pass_bad <= 1'b0;
            state    <= WRITE;
`ifdef RAM_TEST_ERR_INJECT_EN
            injected <= 1'b0;
`endif
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_pattern_tester.sv
// Self-checking bench: table-driven pattern passes with a read-data scoreboard, plus loop, reset and wrap sequences.
module tb_bram_pattern_tester;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 0, loop0 = 0, stop0 = 0, inject0 = 0;
  logic [1:0]  mode0 = 0;
  logic        busy0, done0, pass0, rv0;
  logic [15:0] err0;
  logic [3:0]  fea0, ra0;
  logic [31:0] rd0;

  logic        start1 = 0, loop1 = 0, stop1 = 0, inject1 = 0;
  logic [1:0]  mode1 = 0;
  logic        busy1, done1, pass1, rv1;
  logic [15:0] err1;
  logic [8:0]  fea1, ra1;
  logic [7:0]  rd1;

  bram_pattern_tester #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .SEED(32'h0)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .mode(mode0), .loop(loop0), .stop(stop0),
`ifdef RAM_TEST_ERR_INJECT_EN
    .inject(inject0),
`endif
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_err_addr(fea0),
    .read_addr(ra0), .read_data_out(rd0), .read_valid(rv0));

  bram_pattern_tester #(.DATA_W(8), .ADDR_W(9), .DEPTH(300), .SEED(32'hF0)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .mode(mode1), .loop(loop1), .stop(stop1),
`ifdef RAM_TEST_ERR_INJECT_EN
    .inject(inject1),
`endif
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_err_addr(fea1),
    .read_addr(ra1), .read_data_out(rd1), .read_valid(rv1));

  int errors = 0;
  int checks = 0;

  typedef struct { logic [3:0] addr; logic [31:0] data; } sb_t;
  sb_t sbq[$];

  typedef struct { logic [1:0] mode; int inj; logic exp_pass; int exp_err; int exp_fea; } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer for u0 read stream
  always @(negedge clk) begin
    if (reset_n && rv0) begin
      if (sbq.size() == 0) check("sb_unexpected_read", {60'd0, ra0}, 64'hDEAD);
      else begin
        sb_t e;
        e = sbq.pop_front();
        check("rd_addr", {60'd0, ra0}, {60'd0, e.addr});
        check("rd_data", {32'd0, rd0}, {32'd0, e.data});
      end
    end
  end

  task automatic push_pass(input logic [1:0] m, input int inj);
    logic [31:0] s;
    logic [31:0] d;
    s = 32'd1;
    for (int a = 0; a < 16; a++) begin
      case (m)
        2'd0, 2'd1: d = 32'(a);
        2'd2:       d = s;
        default:    d = 32'd1 << a;
      endcase
      if (a == inj) d[0] = ~d[0];
      sbq.push_back('{addr: 4'(a), data: d});
      s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, {63'd0, busy0}, 0);
    check({tag, "_done"}, {63'd0, done0}, 0);
    check({tag, "_pass"}, {63'd0, pass0}, 1);
    check({tag, "_err"}, {48'd0, err0}, 0);
    check({tag, "_fea"}, {60'd0, fea0}, 0);
    check({tag, "_ra"}, {60'd0, ra0}, 0);
    check({tag, "_rv"}, {63'd0, rv0}, 0);
    check({tag, "_rd"}, {32'd0, rd0}, 0);
    check({tag, "_u1_pass"}, {63'd0, pass1}, 1);
    check({tag, "_u1_busy"}, {63'd0, busy1}, 0);
  endtask

  task automatic run_pass(input vec_t v);
    int n;
    bit got;
    push_pass(v.mode, v.inj);
    mode0 = v.mode;
    start0 = 1;
    @(negedge clk);
    start0 = 0;
    n = 1;
    got = 0;
    while (n <= 200) begin
      inject0 = (v.inj >= 0) && (n == v.inj + 1);
      if (done0) begin got = 1; break; end
      @(negedge clk);
      n++;
    end
    inject0 = 0;
    check("done_latency", got ? 64'(n) : 64'hFFFF, 34);
    check("pass", {63'd0, pass0}, {63'd0, v.exp_pass});
    check("err_count", {48'd0, err0}, 64'(v.exp_err));
    check("first_err_addr", {60'd0, fea0}, 64'(v.exp_fea));
    @(negedge clk);
    check("busy_fall", {63'd0, busy0}, 0);
    check("sb_drained", 64'(sbq.size()), 0);
  endtask

  initial begin
    int n, dones, exp_a;
    bit prev_done, got;

    tbl.push_back('{mode: 2'd0, inj: -1, exp_pass: 1'b1, exp_err: 0, exp_fea: 0});
    tbl.push_back('{mode: 2'd1, inj: -1, exp_pass: 1'b1, exp_err: 0, exp_fea: 0});
    tbl.push_back('{mode: 2'd2, inj: -1, exp_pass: 1'b1, exp_err: 0, exp_fea: 0});
    tbl.push_back('{mode: 2'd3, inj: -1, exp_pass: 1'b1, exp_err: 0, exp_fea: 0});
`ifdef RAM_TEST_ERR_INJECT_EN
    tbl.push_back('{mode: 2'd3, inj: 5, exp_pass: 1'b0, exp_err: 1, exp_fea: 5});
`endif

    repeat (3) @(negedge clk);
    check_reset("reset");
    reset_n = 1;
    @(negedge clk);

    foreach (tbl[i]) run_pass(tbl[i]);

    // Looping: stop the cycle after the 2nd done; a start mid-run must be ignored.
    push_pass(2'd3, -1); push_pass(2'd3, -1); push_pass(2'd3, -1);
    mode0 = 2'd3; loop0 = 1; start0 = 1;
    @(negedge clk);
    start0 = 0; loop0 = 0;
    n = 1; dones = 0; prev_done = 0;
    while (busy0 && n < 400) begin
      if (done0) dones++;
      stop0  = prev_done && (dones == 2);
      start0 = (n == 10);
      mode0  = (n == 10) ? 2'd0 : 2'd3;
      prev_done = done0;
      @(negedge clk);
      n++;
    end
    stop0 = 0; start0 = 0;
    check("loop_dones", 64'(dones), 3);
    check("loop_busy_end", {63'd0, busy0}, 0);
    check("loop_err", {48'd0, err0}, 0);
    check("loop_pass", {63'd0, pass0}, 1);
    check("loop_sb_drained", 64'(sbq.size()), 0);

    // Reset in the middle of the read phase.
    push_pass(2'd0, -1);
    mode0 = 2'd0; start0 = 1;
    @(negedge clk);
    start0 = 0;
    n = 0; got = 0;
    while (n < 100) begin
      if (rv0 && ra0 == 4'd7) begin got = 1; break; end
      @(negedge clk);
      n++;
    end
    check("reach_read7", {63'd0, got}, 1);
    reset_n = 0;
    #1;
    check_reset("midreset");
    sbq.delete();
    @(negedge clk);
    check("midreset_no_done", {63'd0, done0}, 0);
    reset_n = 1;
    @(negedge clk);
    run_pass(tbl[0]);

    // Narrow wide-depth instance: SEED + addr wraps at addr 16.
    mode1 = 2'd1; start1 = 1;
    @(negedge clk);
    start1 = 0;
    n = 1; got = 0; exp_a = 0;
    while (n <= 700) begin
      if (rv1) begin
        check("u1_addr", {55'd0, ra1}, 64'(exp_a));
        check("u1_data", {56'd0, rd1}, {56'd0, 8'(8'hF0 + exp_a)});
        if (exp_a == 16) check("u1_wrap16", {56'd0, rd1}, 0);
        exp_a++;
      end
      if (done1) begin got = 1; break; end
      @(negedge clk);
      n++;
    end
    check("u1_done_latency", got ? 64'(n) : 64'hFFFF, 602);
    check("u1_words", 64'(exp_a), 300);
    check("u1_pass", {63'd0, pass1}, 1);
    check("u1_err", {48'd0, err1}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
